hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It sits beside the forwarding unit and covers the hazards forwarding cannot. It detects load-use hazards between ID and EX, applies branch/jump redirects resolved in EX, and freezes or bubbles the pipeline while instruction or data memory is not ready. It also keeps stall/flush performance counters.

---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/hazard_decode.sv | 34 +++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, NOP encoding and hazard FSM state type
package rv32i_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } hz_state_e;

    function automatic logic uses_rs1(input logic [4:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - combinational load-use detection between ID and EX
module hazard_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_id,
    input  logic [31:0] instr_ex,
    output logic        load_use
);

    logic [4:0] op_id;
    logic [4:0] op_ex;
    logic [4:0] rd_ex;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign op_id  = instr_id[6:2];
    assign op_ex  = instr_ex[6:2];
    assign rd_ex  = instr_ex[11:7];
    assign rs1_id = instr_id[19:15];
    assign rs2_id = instr_id[24:20];

    // Only compare register fields the ID opcode actually reads; immediate bits may alias rd_ex.
    assign rs1_hit = uses_rs1(op_id) && (rs1_id == rd_ex);
    assign rs2_hit = uses_rs2(op_id) && (rs2_id == rd_ex);

    assign load_use = (op_ex == OP_LOAD) && (rd_ex != 5'd0) && (rs1_hit || rs2_hit);

    assign unused_bits = ^{instr_id[31:25], instr_id[14:7], instr_id[1:0],
                           instr_ex[31:12], instr_ex[1:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing with memory-wait FSM and perf counters
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      instr_ex,
    input  logic             brtaken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use;
    logic             dfreeze;
    logic             redirect;

    hazard_decode u_decode (
        .instr_id (instr_id),
        .instr_ex (instr_ex),
        .load_use (load_use)
    );

    assign dfreeze  = dmem_req && !dmem_ready;
    assign redirect = !rst && !dfreeze && brtaken_ex;

    // Control outputs depend only on inputs; the state register only tracks which wait is pending.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (rst) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (dfreeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
        end else if (brtaken_ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (!imem_ready) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dfreeze)
                    state_d = ST_DWAIT;
                else if (!brtaken_ex && !load_use && !imem_ready)
                    state_d = ST_IWAIT;
            end
            ST_DWAIT: begin
                if (dmem_ready)
                    state_d = ST_RUN;
            end
            ST_IWAIT: begin
                if (dfreeze)
                    state_d = ST_DWAIT;
                else if (imem_ready)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_pc)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redirect)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
